// File: rtl/button_conditioner.sv
// Five-channel push-button conditioner: synchronise, debounce, and turn each
// press into a single-cycle pulse. Direction channels auto-repeat while held.

// One button channel: 2-flop synchroniser, debounce counter, pulse logic.
module button_lane #(
  parameter int unsigned DB_CYCLES     = 1000000,
  parameter int unsigned REPEAT_DELAY  = 50000000,
  parameter int unsigned REPEAT_PERIOD = 10000000,
  parameter int unsigned CNT_W         = 32,
  parameter bit          REPEAT_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic pulse_o
);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             stable_q, stable_d;
  logic             pulse_q;
  logic             rise;

  // Two-stage synchroniser; sync_q[1] is the metastability-safe copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], raw_i};
  end

  // Stable level flips only after DB_CYCLES consecutive disagreeing samples.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    if (sync_q[1] != stable_q) begin
      if (db_cnt_q == DB_LAST) stable_d = sync_q[1];
      else                     db_cnt_d = db_cnt_q + CNT_W'(1);
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_q <= '0;
      stable_q <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      stable_q <= stable_d;
    end
  end

  // Rise is taken from the next-state so the pulse lands with the level edge.
  assign rise = stable_d & ~stable_q;

  generate
    if (REPEAT_EN) begin : g_rep
      typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_e;
      localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
      localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
      state_e           state_q;
      logic [CNT_W-1:0] timer_q;

      // Press/delay/repeat FSM. DB_CYCLES >= 2 guarantees the FSM has left
      // DELAY/REPEAT before the next debounced rise can appear.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q <= S_IDLE;
          timer_q <= '0;
          pulse_q <= 1'b0;
        end else begin
          pulse_q <= 1'b0;
          case (state_q)
            S_IDLE: begin
              if (rise) begin
                pulse_q <= 1'b1;
                timer_q <= '0;
                state_q <= S_DELAY;
              end
            end
            S_DELAY: begin
              if (!stable_q) begin
                timer_q <= '0;
                state_q <= S_IDLE;
              end else if (timer_q == RD_LAST) begin
                pulse_q <= 1'b1;
                timer_q <= '0;
                state_q <= S_REPEAT;
              end else begin
                timer_q <= timer_q + CNT_W'(1);
              end
            end
            S_REPEAT: begin
              if (!stable_q) begin
                timer_q <= '0;
                state_q <= S_IDLE;
              end else if (timer_q == RP_LAST) begin
                pulse_q <= 1'b1;
                timer_q <= '0;
              end else begin
                timer_q <= timer_q + CNT_W'(1);
              end
            end
            default: begin
              timer_q <= '0;
              state_q <= S_IDLE;
            end
          endcase
        end
      end
    end else begin : g_norep
      // Non-repeating channel: one pulse per debounced rise.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) pulse_q <= 1'b0;
        else     pulse_q <= rise;
      end
    end
  endgenerate

  assign level_o = stable_q;
  assign pulse_o = pulse_q;
endmodule

// Top: bit order {enter,right,left,down,up}; enter (bit 4) never repeats.
module button_conditioner #(
  parameter int unsigned DB_CYCLES     = 1000000,
  parameter int unsigned REPEAT_DELAY  = 50000000,
  parameter int unsigned REPEAT_PERIOD = 10000000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       enter,
  output logic [4:0] btn_level,
  output logic [4:0] btn_pulse
);
  localparam int NUM_LANES = 5;

  logic [NUM_LANES-1:0] raw;
  assign raw = {enter, right, left, down, up};

  generate
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      button_lane #(
        .DB_CYCLES    (DB_CYCLES),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD),
        .CNT_W        (CNT_W),
        .REPEAT_EN    (g < NUM_LANES - 1)
      ) u_lane (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (raw[g]),
        .level_o(btn_level[g]),
        .pulse_o(btn_pulse[g])
      );
    end
  endgenerate
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DB=4, DELAY=10, PERIOD=3.
// Inputs change 1 ns after a rising edge, so the next edge is the first sample;
// with that, a press pulse appears after the 6th edge following the change.
module tb_button_conditioner;
  logic       clk = 1'b0;
  logic       rst;
  logic       up, down, left, right, enter;
  logic [4:0] btn_level, btn_pulse;

  int n_cmp = 0, n_bad = 0, cyc = 0, t0 = 0;
  int pcnt [5];
  int ptime[5][16];
  logic [4:0] lvl_or;
  int rep_exp[8] = '{6, 16, 19, 22, 25, 28, 31, 34};

  always #5 clk = ~clk;

  button_conditioner #(
    .DB_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
    .enter(enter), .btn_level(btn_level), .btn_pulse(btn_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic mark();
    t0 = cyc;
    lvl_or = '0;
    for (int b = 0; b < 5; b++) pcnt[b] = 0;
  endtask

  // Advance n cycles, logging every pulse offset (relative to t0) per bit.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      lvl_or |= btn_level;
      for (int b = 0; b < 5; b++)
        if (btn_pulse[b]) begin
          if (pcnt[b] < 16) ptime[b][pcnt[b]] = cyc - t0;
          pcnt[b]++;
        end
    end
  endtask

  function automatic int ptotal();
    int s = 0;
    for (int b = 0; b < 5; b++) s += pcnt[b];
    return s;
  endfunction

  task automatic set_btn(input logic [4:0] v);
    {enter, right, left, down, up} = v;
  endtask

  initial begin
    // Reset held with every button pressed.
    rst = 1'b1;
    set_btn(5'h1f);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_level", btn_level, 0);
      chk("rst_pulse", btn_pulse, 0);
    end
    rst = 1'b0;
    mark();
    run(5);
    chk("rr_level_early", lvl_or, 0);
    chk("rr_no_early_pulse", ptotal(), 0);
    run(1);
    chk("rr_pulse", btn_pulse, 5'h1f);
    chk("rr_level", btn_level, 5'h1f);
    run(1);
    chk("rr_pulse_one_cycle", btn_pulse, 0);
    mark();
    set_btn(5'h00);
    run(12);
    chk("rr_release_level", btn_level, 0);
    chk("rr_release_no_pulse", ptotal(), 0);

    // Clean enter press, then release.
    mark();
    set_btn(5'h10);
    run(100);
    chk("enter_cnt", pcnt[4], 1);
    chk("enter_time", ptime[4][0], 6);
    chk("enter_only", ptotal(), 1);
    chk("enter_level", btn_level, 5'h10);
    mark();
    set_btn(5'h00);
    run(5);
    chk("enter_rel_hold", btn_level, 5'h10);
    run(1);
    chk("enter_rel_fall", btn_level, 0);
    run(5);
    chk("enter_rel_nopulse", ptotal(), 0);

    // Bounce on up: 1,0,1,0 every 2 cycles, then a final held rise.
    mark();
    for (int i = 0; i < 4; i++) begin
      set_btn((i % 2 == 0) ? 5'h01 : 5'h00);
      run(2);
    end
    chk("bounce_level", lvl_or, 0);
    chk("bounce_nopulse", ptotal(), 0);
    set_btn(5'h01);
    t0 = cyc;
    run(8);
    chk("bounce_cnt", pcnt[0], 1);
    chk("bounce_time", ptime[0][0], 6);
    chk("bounce_level_up", btn_level, 5'h01);
    set_btn(5'h00);
    run(12);
    chk("bounce_norepeat", pcnt[0], 1);

    // Auto-repeat on right (bit 3) held 30 cycles.
    mark();
    set_btn(5'h08);
    run(30);
    set_btn(5'h00);
    run(20);
    chk("rep_cnt", pcnt[3], 8);
    for (int k = 0; k < 8; k++) chk($sformatf("rep_time%0d", k), ptime[3][k], rep_exp[k]);
    chk("rep_only", ptotal(), 8);
    chk("rep_level", btn_level, 0);

    // Left (bit 2): debounced level held 6 cycles past its pulse, released in DELAY.
    mark();
    set_btn(5'h04);
    run(6);
    set_btn(5'h00);
    run(20);
    chk("delay_rel_cnt", pcnt[2], 1);
    chk("delay_rel_time", ptime[2][0], 6);
    chk("delay_rel_only", ptotal(), 1);

    // Up + down together, then async reset while a repeat pulse is high.
    mark();
    set_btn(5'h03);
    run(22);
    chk("sim_cnt_up", pcnt[0], 4);
    chk("sim_cnt_dn", pcnt[1], 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("sim_up_t%0d", k), ptime[0][k], rep_exp[k]);
      chk($sformatf("sim_dn_t%0d", k), ptime[1][k], rep_exp[k]);
    end
    chk("sim_pulse_now", btn_pulse, 5'h03);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_pulse", btn_pulse, 0);
    chk("async_rst_level", btn_level, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst2_pulse", btn_pulse, 0);
    end
    rst = 1'b0;
    mark();
    run(8);
    chk("post_rst_up_cnt", pcnt[0], 1);
    chk("post_rst_up_t", ptime[0][0], 6);
    chk("post_rst_dn_cnt", pcnt[1], 1);
    chk("post_rst_dn_t", ptime[1][0], 6);
    chk("post_rst_level", btn_level, 5'h03);
    set_btn(5'h00);
    run(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
